// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - shared types, constants and pattern helpers for the wave phase sequencer
package wave_pkg;

    localparam int          WAVE_NUM_PHASES   = 4;
    localparam int          WAVE_LEN_W        = 16;
    localparam logic [31:0] WAVE_DEFAULT_SEED = 32'hACE1_2468;

    localparam int LFSR_TAP_A = 31;
    localparam int LFSR_TAP_B = 21;
    localparam int LFSR_TAP_C = 1;
    localparam int LFSR_TAP_D = 0;

    typedef enum logic [1:0] {
        WM_COUNT  = 2'd0,
        WM_RANDOM = 2'd1,
        WM_XZ     = 2'd2,
        WM_FOUR   = 2'd3
    } wave_mode_e;

    typedef enum logic [1:0] {
        WS_IDLE = 2'd0,
        WS_RUN  = 2'd1,
        WS_DONE = 2'd2
    } wave_state_e;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D]};
    endfunction

    function automatic logic [3:0] xz_nibble(input logic [1:0] sel, input logic [2:0] d);
        case (sel)
            2'd0:    return 4'bxxxx;
            2'd1:    return {d, 1'bx};
            2'd2:    return 4'bzzzz;
            default: return {d, 1'bz};
        endcase
    endfunction

    function automatic logic [7:0] four_byte(input logic [3:0] lo, input logic [7:0] hi);
        return (lo == 4'h0) ? 8'hxx : hi;
    endfunction

    // Only the low 16 LFSR bits ever reach the output byte.
    function automatic logic [7:0] wave_pattern(input wave_mode_e mode, input logic [7:0] count,
                                                input logic [15:0] s);
        case (mode)
            WM_COUNT:  return count;
            WM_RANDOM: return s[7:0];
            WM_XZ:     return {xz_nibble(s[1:0], s[6:4]), xz_nibble(s[3:2], s[10:8])};
            default:   return four_byte(s[3:0], s[15:8]);
        endcase
    endfunction

endpackage

// File: rtl/wave_phase_pick.sv
// rtl/wave_phase_pick.sv - combinational finder for the next slot with a nonzero length
module wave_phase_pick
    import wave_pkg::*;
#(
    parameter int NUM_PHASES = WAVE_NUM_PHASES,
    parameter int LEN_W      = WAVE_LEN_W
) (
    input  logic [NUM_PHASES-1:0][LEN_W-1:0] lens,
    input  logic [1:0]                       cur_idx,
    input  logic                             from_start,
    output logic [1:0]                       next_idx,
    output logic                             found,
    output logic                             wrapped
);

    logic [1:0] base;
    logic [2:0] sum;
    logic [1:0] slot;

    // Searching from the start is the same scan as searching past the last slot.
    assign base = from_start ? 2'(NUM_PHASES - 1) : cur_idx;

    always_comb begin
        next_idx = 2'd0;
        found    = 1'b0;
        wrapped  = 1'b0;
        sum      = 3'd0;
        slot     = 2'd0;
        for (int off = 1; off <= NUM_PHASES; off++) begin
            sum  = {1'b0, base} + 3'(off);
            slot = sum[1:0];
            if (!found && (lens[slot] != '0)) begin
                found    = 1'b1;
                next_idx = slot;
                wrapped  = sum[2] && !from_start;
            end
        end
    end

endmodule

// File: rtl/wave_phase_sequencer.sv
// rtl/wave_phase_sequencer.sv - four-slot pattern sequencer with registered four-state output
module wave_phase_sequencer
    import wave_pkg::*;
#(
    parameter int          NUM_PHASES = WAVE_NUM_PHASES,
    parameter int          LEN_W      = WAVE_LEN_W,
    parameter logic [31:0] SEED       = WAVE_DEFAULT_SEED
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        cfg_loop,
    input  logic [2*NUM_PHASES-1:0]     cfg_mode,
    input  logic [LEN_W*NUM_PHASES-1:0] cfg_len,
    output logic                        busy,
    output logic                        done,
    output logic                        data_valid,
    output logic [7:0]                  data_out,
    output logic [1:0]                  phase_idx,
    output logic [1:0]                  phase_mode,
    output logic [31:0]                 cycle_cnt,
    output logic [31:0]                 cycle_cnt_rev
);

    wave_state_e                      state_q, state_d;
    logic [NUM_PHASES-1:0][LEN_W-1:0] len_sh, pick_lens;
    logic [NUM_PHASES-1:0][1:0]       mode_sh;
    logic                             loop_sh;
    logic [1:0]                       cur_idx, pick_idx;
    logic                             pick_found, pick_wrapped;
    logic [LEN_W-1:0]                 elem_cnt;
    logic [31:0]                      lfsr;
    logic                             accept, emit, last_elem, advance_ok;
    logic                             busy_d, done_d, valid_d;
    logic [7:0]                       data_d;
    logic [1:0]                       idx_d, mode_d;

    assign accept     = (state_q == WS_IDLE) && start && !stop;
    assign emit       = (state_q == WS_RUN) && !stop;
    assign last_elem  = (elem_cnt == len_sh[cur_idx] - LEN_W'(1));
    assign advance_ok = pick_found && (!pick_wrapped || loop_sh);
    // In IDLE the live config is scanned so the first slot is known at the accepting edge.
    assign pick_lens  = (state_q == WS_IDLE) ? cfg_len : len_sh;

    wave_phase_pick #(
        .NUM_PHASES (NUM_PHASES),
        .LEN_W      (LEN_W)
    ) u_pick (
        .lens       (pick_lens),
        .cur_idx    (cur_idx),
        .from_start (state_q == WS_IDLE),
        .next_idx   (pick_idx),
        .found      (pick_found),
        .wrapped    (pick_wrapped)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= WS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WS_IDLE: begin
                if (accept) begin
                    state_d = pick_found ? WS_RUN : WS_DONE;
                end
            end
            WS_RUN: begin
                if (stop) begin
                    state_d = WS_IDLE;
                end else if (last_elem && !advance_ok) begin
                    state_d = WS_DONE;
                end
            end
            default: state_d = WS_IDLE;
        endcase
    end

    always_comb begin
        valid_d = emit;
        busy_d  = emit;
        done_d  = (state_q == WS_DONE) && !stop;
        data_d  = data_out;
        idx_d   = phase_idx;
        mode_d  = phase_mode;
        if (emit) begin
            data_d = wave_pattern(wave_mode_e'(mode_sh[cur_idx]), elem_cnt[7:0], lfsr[15:0]);
            idx_d  = cur_idx;
            mode_d = mode_sh[cur_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            len_sh        <= '0;
            mode_sh       <= '0;
            loop_sh       <= 1'b0;
            cur_idx       <= 2'd0;
            elem_cnt      <= '0;
            lfsr          <= SEED;
            busy          <= 1'b0;
            done          <= 1'b0;
            data_valid    <= 1'b0;
            data_out      <= 8'h00;
            phase_idx     <= 2'd0;
            phase_mode    <= 2'd0;
            cycle_cnt     <= 32'd0;
            cycle_cnt_rev <= 32'd0;
        end else begin
            cycle_cnt     <= cycle_cnt + 32'd1;
            cycle_cnt_rev <= cycle_cnt_rev - 32'd1;
            if (accept) begin
                len_sh   <= cfg_len;
                mode_sh  <= cfg_mode;
                loop_sh  <= cfg_loop;
                lfsr     <= SEED;
                cur_idx  <= pick_idx;
                elem_cnt <= '0;
            end else if (emit) begin
                lfsr <= lfsr_next(lfsr);
                if (last_elem) begin
                    cur_idx  <= pick_idx;
                    elem_cnt <= '0;
                end else begin
                    elem_cnt <= elem_cnt + LEN_W'(1);
                end
            end
            busy       <= busy_d;
            done       <= done_d;
            data_valid <= valid_d;
            data_out   <= data_d;
            phase_idx  <= idx_d;
            phase_mode <= mode_d;
        end
    end

endmodule

// File: doc/wave_phase_sequencer.md
# wave_phase_sequencer

Programmable stimulus sequencer for the waveform-sample environment. Sequences up to four phases, each with its own pattern mode (counter, random, X/Z, four-state) and length, into one registered 8-bit four-state output with a valid strobe. Provides start/stop/busy/done control and optional looping. Also keeps free-running up/down cycle counters for waveform alignment.

## Interface
- NUM_PHASES, 4, number of phase slots; fixed at 4 in this revision, so the phase index is 2 bits.
- LEN_W, 16, width of each phase length field.
- SEED, 32'hACE1_2468, LFSR value loaded at reset and on each accepted start; must be nonzero.
- Reset is `reset`, synchronous, active-low. Clock is `clk`.
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request a run; accepted only in IDLE.
- stop  in  1  abort; takes priority over everything except reset.
- cfg_loop  in  1  restart at the first phase after the last one instead of finishing.
- cfg_mode  in  2*NUM_PHASES  per-phase mode, slot i at [2i+1:2i].
- cfg_len  in  LEN_W*NUM_PHASES  per-phase length in cycles; 0 means the phase is skipped.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on normal completion.
- data_valid  out  1  data_out is meaningful.
- data_out  out  8  pattern byte; may carry X/Z.
- phase_idx  out  2  slot currently driving data_out.
- phase_mode  out  2  mode of that slot.
- cycle_cnt  out  32  free-running up counter.
- cycle_cnt_rev  out  32  free-running down counter.

## Operation
- Modes:
  - 0 COUNT: data_out = in-phase element counter [7:0]; the counter restarts at 0 for each phase.
  - 1 RANDOM: data_out = lfsr[7:0].
  - 2 XZ: each nibble is built from a 2-bit selector and 3 data bits:
    - Selector 0 gives 4'hx, 1 gives {d,1'bx}, 2 gives 4'hz, 3 gives {d,1'bz}.
    - High nibble: selector lfsr[1:0], d = lfsr[6:4].
    - Low nibble: selector lfsr[3:2], d = lfsr[10:8].
  - 3 FOUR: if lfsr[3:0]==0, data_out = 8'hxx; otherwise data_out = lfsr[15:8].
- LFSR:
  - Update: lfsr <= {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}.
  - Advances only on cycles where data_valid is driven high; holds otherwise.
- State machine: IDLE, RUN, DONE.
  - IDLE, start=1: latch cfg_* into shadow registers and reload the LFSR with SEED.
    - If any length is nonzero, go to RUN at the first nonzero slot.
    - If all lengths are 0, go to DONE.
  - RUN: emit one element per cycle.
    - When the element count reaches len-1, move to the next nonzero slot.
    - Past the last nonzero slot with cfg_loop=1 (shadowed): wrap to the first nonzero slot; the LFSR is not reseeded.
    - Past the last nonzero slot with cfg_loop=0: go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- stop=1 in RUN or DONE: go to IDLE at the next edge. data_valid=0, busy=0, no done pulse.
- start while busy is ignored. cfg_* changes during RUN have no effect.
- Reset values:
  - busy=0, done=0, data_valid=0, data_out=8'h00, phase_idx=0, phase_mode=0.
  - cycle_cnt=0, cycle_cnt_rev=0, lfsr=SEED, state IDLE.
- Counters: cycle_cnt +1 and cycle_cnt_rev -1 every non-reset cycle. Both wrap modulo 2^32, regardless of state.
- When data_valid=0, data_out holds its last value.

## Timing
- start sampled high at edge k (state IDLE): busy=1 and the first data_valid at edge k+1.
- A non-looping run with total length L = sum of nonzero lengths:
  - data_valid is high for edges k+1..k+L, contiguous. Skipped slots add no bubbles.
  - done=1 and busy=0 after edge k+L+1; done clears at k+L+2.
- All-zero config: no valid cycles; done pulses after edge k+1.
- phase_idx and phase_mode change on the same edge as the first element of the new phase.
- stop and start high together in IDLE: stop wins, nothing starts.
- Reset mid-run: all outputs take their reset values at that edge.

## Structure
- Shared package wave_pkg:
  - mode enum (WM_COUNT, WM_RANDOM, WM_XZ, WM_FOUR).
  - state enum.
  - LFSR tap constants and the default SEED.
  - pattern-function helpers (XZ nibble builder, FOUR byte builder).
- Sub-module wave_phase_pick: combinational next-nonzero-slot finder.
  - Inputs: shadow lengths, current index, a from-start flag.
  - Outputs: next index, found flag, wrapped flag.

## Test plan
- Modes {0,1,2,3}, lengths {3,0,2,1}, start at edge 10 → six valid cycles at edges 11-16.
  - phase_idx sequence 0,0,0,2,2,3.
  - COUNT bytes 00,01,02.
  - done after edge 17.
- All lengths 0, start → no data_valid; single done pulse one edge after start; busy never high.
- cfg_loop=1, single slot of mode 1, length 4 → data_valid continuous; LFSR continues across the wrap; stop at element 7 → IDLE next edge, no done.
- Mode 2 and mode 3 with a known SEED → data_out matches a reference-model LFSR byte-for-byte, including the 8'hxx case whenever lfsr[3:0]==0.
- start pulsed again while busy, plus cfg changes mid-run → ignored; output stream is identical to an undisturbed run.
- reset asserted mid-RUN → every output at its reset value at that edge; cycle_cnt=0, cycle_cnt_rev=0; a subsequent start reproduces the first run exactly.
